// File: rtl/tlp_mwr_encoder.sv
// tlp_mwr_encoder: turns local posted-write requests into 3DW-header
// Memory Write TLPs on a 64-bit AXI4-Stream TX interface. The payload
// stream is shifted by one DW so it packs directly behind the 3DW header.
module tlp_mwr_encoder #(
  parameter int unsigned MAX_LEN_DW = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        lnk_up,
  input  logic [7:0]  cfg_bus_number,
  input  logic [4:0]  cfg_device_number,
  input  logic [2:0]  cfg_func_number,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [9:0]  req_len,
  input  logic [7:0]  req_tag,
  input  logic [3:0]  req_first_be,
  input  logic [3:0]  req_last_be,
  output logic        req_err,
  input  logic        dat_tvalid,
  output logic        dat_tready,
  input  logic [63:0] dat_tdata,
  input  logic        enc_tx_tready,
  output logic        enc_tx_tvalid,
  output logic        enc_tx_tlast,
  output logic [63:0] enc_tx_tdata,
  output logic [7:0]  enc_tx_tstrb,
  output logic        done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HDR0 = 2'd1;
  localparam logic [1:0] HDR1 = 2'd2;
  localparam logic [1:0] DATA = 2'd3;

  localparam logic [9:0] MAX_LEN = 10'(MAX_LEN_DW);

  logic [1:0]  state_q,      state_d;
  logic        tvalid_q,     tvalid_d;
  logic        tlast_q,      tlast_d;
  logic [63:0] tdata_q,      tdata_d;
  logic [7:0]  tstrb_q,      tstrb_d;
  logic [31:0] hold_q,       hold_d;
  logic [9:0]  words_left_q, words_left_d;
  logic [29:0] addr_q,       addr_d;
  logic        len_odd_q,    len_odd_d;
  logic        done_q,       done_d;
  logic        req_err_q,    req_err_d;

  logic advance;
  logic try_hdr1;
  logic try_data;
  logic need_word;
  logic pop;
  logic len_bad;

  // Address bits [1:0] are dropped: the TLP carries a DW-aligned address.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^req_addr[1:0];

  // Beat sequencing, payload realignment and request handling.
  // A payload word is consumed at the moment the beat that carries its low
  // DW is loaded into the output register, so dat_tready follows the
  // output slot becoming free (beat handshake, or an empty slot after a
  // source stall) rather than a combinational beat.
  always_comb begin
    state_d      = state_q;
    tvalid_d     = tvalid_q;
    tlast_d      = tlast_q;
    tdata_d      = tdata_q;
    tstrb_d      = tstrb_q;
    hold_d       = hold_q;
    words_left_d = words_left_q;
    addr_d       = addr_q;
    len_odd_d    = len_odd_q;
    done_d       = 1'b0;
    req_err_d    = 1'b0;

    req_ready = !reset && lnk_up && (state_q == IDLE);
    len_bad   = (req_len == '0) || (req_len > MAX_LEN);
    advance   = tvalid_q && enc_tx_tready;

    try_hdr1 = 1'b0;
    try_data = 1'b0;
    case (state_q)
      HDR0: try_hdr1 = advance;
      HDR1: begin
        try_hdr1 = !tvalid_q;
        try_data = advance && !tlast_q;
      end
      DATA: try_data = !tvalid_q || (advance && !tlast_q);
      default: ;
    endcase

    need_word  = try_hdr1 || (try_data && (words_left_q != '0));
    dat_tready = need_word && lnk_up && !reset;
    pop        = dat_tready && dat_tvalid;

    if (state_q == IDLE) begin
      if (req_valid && req_ready) begin
        if (len_bad) begin
          req_err_d = 1'b1;
        end else begin
          state_d      = HDR0;
          tvalid_d     = 1'b1;
          tlast_d      = 1'b0;
          tstrb_d      = '1;
          tdata_d      = {cfg_bus_number, cfg_device_number, cfg_func_number,
                          req_tag,
                          (req_len == 10'd1) ? 4'h0 : req_last_be,
                          req_first_be,
                          32'h4000_0000 | {22'h0, req_len}};
          addr_d       = req_addr[31:2];
          len_odd_d    = req_len[0];
          words_left_d = 10'((11'(req_len) + 11'd1) >> 1);
        end
      end
    end else if (!lnk_up) begin
      // Link loss: abandon the TLP without a done pulse.
      state_d      = IDLE;
      tvalid_d     = 1'b0;
      tlast_d      = 1'b0;
      tdata_d      = '0;
      tstrb_d      = '0;
      words_left_d = '0;
      hold_d       = '0;
    end else if (advance && tlast_q) begin
      state_d  = IDLE;
      done_d   = 1'b1;
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
      tdata_d  = '0;
      tstrb_d  = '0;
      hold_d   = '0;
    end else if (try_hdr1) begin
      state_d = HDR1;
      if (pop) begin
        tvalid_d     = 1'b1;
        tdata_d      = {dat_tdata[31:0], addr_q, 2'b00};
        tstrb_d      = '1;
        tlast_d      = (words_left_q == 10'd1) && len_odd_q;
        hold_d       = dat_tdata[63:32];
        words_left_d = words_left_q - 10'd1;
      end else begin
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
        tdata_d  = '0;
        tstrb_d  = '0;
      end
    end else if (try_data) begin
      state_d = DATA;
      if (words_left_q == '0) begin
        // Even length: the last high DW is flushed on its own half beat.
        tvalid_d = 1'b1;
        tdata_d  = {32'h0, hold_q};
        tstrb_d  = 8'h0F;
        tlast_d  = 1'b1;
      end else if (pop) begin
        tvalid_d     = 1'b1;
        tdata_d      = {dat_tdata[31:0], hold_q};
        tstrb_d      = '1;
        tlast_d      = (words_left_q == 10'd1) && len_odd_q;
        hold_d       = dat_tdata[63:32];
        words_left_d = words_left_q - 10'd1;
      end else begin
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
        tdata_d  = '0;
        tstrb_d  = '0;
      end
    end
  end

  // State, output register and payload hold register update.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      tdata_q      <= '0;
      tstrb_q      <= '0;
      hold_q       <= '0;
      words_left_q <= '0;
      addr_q       <= '0;
      len_odd_q    <= 1'b0;
      done_q       <= 1'b0;
      req_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      tvalid_q     <= tvalid_d;
      tlast_q      <= tlast_d;
      tdata_q      <= tdata_d;
      tstrb_q      <= tstrb_d;
      hold_q       <= hold_d;
      words_left_q <= words_left_d;
      addr_q       <= addr_d;
      len_odd_q    <= len_odd_d;
      done_q       <= done_d;
      req_err_q    <= req_err_d;
    end
  end

  assign enc_tx_tvalid = tvalid_q;
  assign enc_tx_tlast  = tlast_q;
  assign enc_tx_tdata  = tdata_q;
  assign enc_tx_tstrb  = tstrb_q;
  assign done          = done_q;
  assign req_err       = req_err_q;

endmodule
